// File: rtl/genius_timer_pkg.sv
// Shared types and default durations for the Genius game timers.
package genius_timer_pkg;

  // Per-timer state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  // Default timing, also used by the Genius top level.
  localparam int unsigned DEF_TICK_DIV = 50000;
  localparam int unsigned DEF_T1_BASE  = 800;
  localparam int unsigned DEF_T1_STEP  = 40;
  localparam int unsigned DEF_T1_MIN   = 200;
  localparam int unsigned DEF_T2_DUR   = 3000;
  localparam int unsigned DEF_LVL_W    = 5;
  localparam int unsigned DEF_CNT_W    = 16;

endpackage

// File: rtl/genius_down_timer.sv
// One tick-driven down timer: IDLE -> RUN -> DONE, restartable by load.
module genius_down_timer
  import genius_timer_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] dur,
  input  logic             tick,
  output logic             ended,
  output logic             busy
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, count and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ended   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ended   <= (state_d == DONE);
      busy    <= (state_d == RUN);
    end
  end

  // Next state: load wins over a same-cycle tick, so a restart never expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = RUN;
      cnt_d   = dur;
    end else if ((state_q == RUN) && tick) begin
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        state_d = DONE;
        cnt_d   = '0;
      end
    end
  end

endmodule

// File: rtl/genius_timer_sched.sv
// Two game timers sharing a 1 ms prescaler; timer 1 shortens with level.
module genius_timer_sched
  import genius_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned T1_BASE  = DEF_T1_BASE,
  parameter int unsigned T1_STEP  = DEF_T1_STEP,
  parameter int unsigned T1_MIN   = DEF_T1_MIN,
  parameter int unsigned T2_DUR   = DEF_T2_DUR,
  parameter int unsigned LVL_W    = DEF_LVL_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START_1,
  input  logic             START_2,
  input  logic [LVL_W-1:0] LEVEL,
  input  logic             HOLD,
  output logic             END_1,
  output logic             END_2,
  output logic             BUSY_1,
  output logic             BUSY_2,
  output logic             TICK
);

  localparam int unsigned PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PROD_W = LVL_W + CNT_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [PROD_W-1:0] prod_c, diff_c;
  logic [CNT_W-1:0]  d1_c;
  logic [CNT_W-1:0]  d2_c;
  logic              tick_en_c;

  // Free-running prescaler wrap.
  always_comb begin
    pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
  end

  // Prescaler register; TICK is registered so it is high exactly while pre_q is at the last count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q <= '0;
      TICK  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      TICK  <= (pre_d == PRE_LAST);
    end
  end

  // Timer-1 duration: base minus level ramp, floored, saturating instead of wrapping.
  always_comb begin
    prod_c = PROD_W'(LEVEL) * PROD_W'(T1_STEP);
    diff_c = PROD_W'(T1_BASE) - prod_c;
    if (prod_c >= PROD_W'(T1_BASE)) begin
      d1_c = CNT_W'(T1_MIN);
    end else if (diff_c < PROD_W'(T1_MIN)) begin
      d1_c = CNT_W'(T1_MIN);
    end else begin
      d1_c = CNT_W'(diff_c);
    end
  end

  // HOLD masks ticks to both timers while the prescaler keeps running.
  always_comb begin
    tick_en_c = TICK & ~HOLD;
    d2_c      = CNT_W'(T2_DUR);
  end

  genius_down_timer #(.CNT_W(CNT_W)) u_timer_1 (
    .clk   (CLK),
    .reset (RESET),
    .load  (START_1),
    .dur   (d1_c),
    .tick  (tick_en_c),
    .ended (END_1),
    .busy  (BUSY_1)
  );

  genius_down_timer #(.CNT_W(CNT_W)) u_timer_2 (
    .clk   (CLK),
    .reset (RESET),
    .load  (START_2),
    .dur   (d2_c),
    .tick  (tick_en_c),
    .ended (END_2),
    .busy  (BUSY_2)
  );

endmodule

// File: tb/tb_genius_timer_sched.sv
// Directed bench for genius_timer_sched with small timing parameters.
module tb_genius_timer_sched;

  localparam int unsigned LVL_W = 5;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             START_1 = 1'b0;
  logic             START_2 = 1'b0;
  logic             HOLD = 1'b0;
  logic [LVL_W-1:0] LEVEL = '0;
  logic             END_1, END_2, BUSY_1, BUSY_2, TICK;

  int checks = 0;
  int failures = 0;

  genius_timer_sched #(
    .TICK_DIV (4),
    .T1_BASE  (10),
    .T1_STEP  (2),
    .T1_MIN   (3),
    .T2_DUR   (6),
    .LVL_W    (LVL_W),
    .CNT_W    (16)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START_1 (START_1),
    .START_2 (START_2),
    .LEVEL   (LEVEL),
    .HOLD    (HOLD),
    .END_1   (END_1),
    .END_2   (END_2),
    .BUSY_1  (BUSY_1),
    .BUSY_2  (BUSY_2),
    .TICK    (TICK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge CLK);
    #1;
  endtask

  // Cycles from now until the first TICK (prescaler phase probe).
  task automatic first_tick_latency(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (TICK) break;
      lat++;
    end
  endtask

  // Wait for END of the selected timer; counts unheld ticks while it is busy.
  task automatic wait_end(input int sel, output int ticks, output int cyc, output bit ok);
    logic e, b;
    ticks = 0;
    cyc   = 0;
    ok    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      e = (sel == 1) ? END_1 : END_2;
      b = (sel == 1) ? BUSY_1 : BUSY_2;
      if (e) begin
        ok = 1'b1;
        break;
      end
      if (TICK && b && !HOLD) ticks++;
      cyc++;
    end
  endtask

  // Count n ticks of a running timer 1, flagging any early expiry.
  task automatic count_ticks1(input int n, input string tag);
    int  t;
    bit  early;
    t     = 0;
    early = 1'b0;
    for (int i = 0; i < 400 && t < n; i++) begin
      @(negedge CLK);
      if (END_1) early = 1'b1;
      if (TICK && BUSY_1 && !HOLD) t++;
    end
    check({tag, "_ticks"}, t, n);
    check({tag, "_no_early_end"}, int'(early), 0);
  endtask

  // Pulse START_1 at a level, scramble LEVEL, and check the resulting duration.
  task automatic run_t1(input logic [LVL_W-1:0] lvl, input int d, input string tag);
    int ticks, cyc;
    bit ok;
    next_edge();
    START_1 = 1'b1;
    LEVEL   = lvl;
    next_edge();
    START_1 = 1'b0;
    LEVEL   = 5'd31;
    check({tag, "_busy"}, int'(BUSY_1), 1);
    check({tag, "_end_low"}, int'(END_1), 0);
    wait_end(1, ticks, cyc, ok);
    check({tag, "_timeout"}, int'(ok), 1);
    check({tag, "_dur"}, ticks, d);
    check({tag, "_window"}, int'(cyc >= 4 * (d - 1) + 1 && cyc <= 4 * d + 1), 1);
    check({tag, "_busy_off"}, int'(BUSY_1), 0);
  endtask

  initial begin
    int  lat, ticks, cyc, t, t1, t2, hc;
    bit  ok, bad, bad2;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_end1", int'(END_1), 0);
    check("rst_end2", int'(END_2), 0);
    check("rst_busy1", int'(BUSY_1), 0);
    check("rst_busy2", int'(BUSY_2), 0);
    check("rst_tick", int'(TICK), 0);
    RESET = 1'b0;
    first_tick_latency(lat);
    check("rst_presc_phase", lat, 3);

    // Level ramp, floor and saturation
    run_t1(5'd0, 10, "lvl0");
    repeat (8) next_edge();
    check("lvl0_end_held", int'(END_1), 1);
    check("lvl0_busy_held", int'(BUSY_1), 0);
    run_t1(5'd2, 6, "lvl2");
    run_t1(5'd3, 4, "lvl3");
    run_t1(5'd4, 3, "lvl4_floor");
    run_t1(5'd16, 3, "lvl16_sat");

    // Restart mid-run
    next_edge();
    START_1 = 1'b1;
    LEVEL   = 5'd0;
    next_edge();
    START_1 = 1'b0;
    count_ticks1(5, "rs_first");
    next_edge();
    START_1 = 1'b1;
    next_edge();
    START_1 = 1'b0;
    check("rs_busy", int'(BUSY_1), 1);
    check("rs_end_low", int'(END_1), 0);
    wait_end(1, ticks, cyc, ok);
    check("rs_timeout", int'(ok), 1);
    check("rs_dur", ticks, 10);

    // Simultaneous starts
    next_edge();
    START_1 = 1'b1;
    START_2 = 1'b1;
    LEVEL   = 5'd0;
    next_edge();
    START_1 = 1'b0;
    START_2 = 1'b0;
    check("sim_busy1", int'(BUSY_1), 1);
    check("sim_busy2", int'(BUSY_2), 1);
    t  = 0;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (END_2 && t2 < 0) t2 = t;
      if (END_1) begin
        t1 = t;
        break;
      end
      if (TICK && BUSY_1) t++;
    end
    check("sim_end2_ticks", t2, 6);
    check("sim_end1_ticks", t1, 10);
    check("sim_end2_held", int'(END_2), 1);
    next_edge();
    START_2 = 1'b1;
    next_edge();
    START_2 = 1'b0;
    check("sim_restart2_end", int'(END_2), 0);
    check("sim_restart2_busy", int'(BUSY_2), 1);
    check("sim_end1_kept", int'(END_1), 1);
    wait_end(2, ticks, cyc, ok);
    check("sim_t2_timeout", int'(ok), 1);
    check("sim_t2_dur", ticks, 6);

    // HOLD freezes a running timer and keeps a done timer done
    next_edge();
    START_1 = 1'b1;
    LEVEL   = 5'd0;
    next_edge();
    START_1 = 1'b0;
    count_ticks1(3, "hold_pre");
    next_edge();
    HOLD = 1'b1;
    hc   = 0;
    bad  = 1'b0;
    bad2 = 1'b0;
    for (int i = 0; i < 200 && hc < 20; i++) begin
      @(negedge CLK);
      if (TICK) hc++;
      if (END_1 || !BUSY_1) bad = 1'b1;
      if (!END_2) bad2 = 1'b1;
    end
    check("hold_ticks_seen", hc, 20);
    check("hold_t1_frozen", int'(bad), 0);
    check("hold_t2_done", int'(bad2), 0);
    next_edge();
    HOLD = 1'b0;
    wait_end(1, ticks, cyc, ok);
    check("hold_timeout", int'(ok), 1);
    check("hold_remaining", ticks, 7);

    // Reset in the expiry cycle discards the expiry
    next_edge();
    START_1 = 1'b1;
    LEVEL   = 5'd0;
    next_edge();
    START_1 = 1'b0;
    count_ticks1(9, "rst_pre");
    repeat (4) next_edge();
    check("rst_in_expiry_cycle", int'(TICK), 1);
    check("rst_pending", int'(BUSY_1), 1);
    RESET = 1'b1;
    next_edge();
    RESET = 1'b0;
    check("rst_mid_end1", int'(END_1), 0);
    check("rst_mid_busy1", int'(BUSY_1), 0);
    check("rst_mid_end2", int'(END_2), 0);
    check("rst_mid_tick", int'(TICK), 0);
    first_tick_latency(lat);
    check("rst_mid_presc_phase", lat, 3);
    check("rst_mid_no_late_end", int'(END_1), 0);
    run_t1(5'd0, 10, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
